// File: rtl/a23_run_ctrl.sv
// Run sequencer for a23_gc_main: reset hold, cycle count until terminate, output-memory dump.
// Optional run-cycle limit enabled by defining A23_RUN_TIMEOUT_EN.
module a23_run_ctrl #(
  parameter int OUT_MEM_SIZE = 64,
  parameter int RST_CYCLES   = 3,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [CNT_W-1:0]           cycle_count,
  output logic                       core_rst,
  input  logic                       core_terminate,
  input  logic [OUT_MEM_SIZE*32-1:0] core_o,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int IDX_W = (OUT_MEM_SIZE > 1) ? $clog2(OUT_MEM_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(OUT_MEM_SIZE - 1);
  localparam logic [7:0]       HOLD_INIT = 8'(RST_CYCLES - 1);

  if ((RST_CYCLES < 1) || (RST_CYCLES > 255) || (MAX_CYCLES < 1) || (OUT_MEM_SIZE < 1)) begin : g_param_check
    $error("a23_run_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       hold_reg, hold_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             done_reg, done_next;
  logic             snap_load;
  logic             hit_limit;
  logic [31:0]      snap_mem [OUT_MEM_SIZE];

`ifdef A23_RUN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LIMIT_AT = CNT_W'(MAX_CYCLES - 1);
  logic timeout_reg;

  // The limit fires on the edge where the count reaches MAX_CYCLES; terminate wins a tie.
  assign hit_limit = (state_reg == RUN) && !core_terminate && (count_reg == LIMIT_AT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_reg <= 1'b0;
    else if ((state_reg == IDLE) && start)
      timeout_reg <= 1'b0;
    else if (hit_limit)
      timeout_reg <= 1'b1;
  end

  assign timeout = timeout_reg;
`else
  assign hit_limit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      count_reg <= '0;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_MEM_SIZE; i++)
        snap_mem[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < OUT_MEM_SIZE; i++)
        snap_mem[i] <= core_o[32*i +: 32];
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    snap_load  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = HOLD;
          hold_next  = HOLD_INIT;
          count_next = '0;
        end
      end
      HOLD: begin
        if (hold_reg == 8'd0)
          state_next = RUN;
        else
          hold_next = hold_reg - 8'd1;
      end
      RUN: begin
        if (core_terminate) begin
          snap_load  = 1'b1;
          idx_next   = '0;
          state_next = DRAIN;
        end else begin
          if (count_reg != {CNT_W{1'b1}})
            count_next = count_reg + CNT_W'(1);
          if (hit_limit) begin
            snap_load  = 1'b1;
            idx_next   = '0;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_reg == LAST_IDX) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state_reg != IDLE);
  assign core_rst    = (state_reg != RUN);
  assign done        = done_reg;
  assign cycle_count = count_reg;
  assign out_valid   = (state_reg == DRAIN);
  assign out_last    = out_valid && (idx_reg == LAST_IDX);
  // Outside DRAIN the data bus reads zero rather than a stale snapshot word.
  assign out_data    = out_valid ? snap_mem[idx_reg] : 32'd0;

endmodule

// File: doc/a23_run_ctrl.md
# a23_run_ctrl

Run sequencer for the `a23_gc_main` garbled-circuit ARM core. It holds the core in reset for a programmed number of cycles, then releases it and counts clock cycles until `terminate`. It snapshots the core's output memory and streams it out one 32-bit word at a time over a valid/ready handshake. It replaces the testbench-only reset/count/dump loop with synthesizable control usable on FPGA and in system benches.

## Interface
Parameters:
- `OUT_MEM_SIZE`, 64, number of 32-bit output words on `core_o`.
- `RST_CYCLES`, 3, cycles `core_rst` stays high after `start`; legal range 1..255.
- `CNT_W`, 32, width of the cycle counter.
- `MAX_CYCLES`, 1000000, run-cycle limit; used only with `A23_RUN_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last output word is accepted.
- `timeout`  out  1  sticky flag: the last run hit `MAX_CYCLES`; cleared on `start`.
- `cycle_count`  out  CNT_W  run cycles of the last or current run.
- `core_rst`  out  1  reset to the core.
- `core_terminate`  in  1  terminate from the core.
- `core_o`  in  OUT_MEM_SIZE*32  output memory of the core; word i is at bits [32i+31:32i].
- `out_data`  out  32  streamed output word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_last`  out  1  high with the final word (index OUT_MEM_SIZE-1).

## Operation
- **State machine:** IDLE, HOLD, RUN, DRAIN.
- **IDLE:** `core_rst`=1.
  - `start`=1 → HOLD. The hold counter loads RST_CYCLES-1, `cycle_count` clears to 0, and `timeout` clears.
- **HOLD:** `core_rst`=1. The hold counter decrements each cycle.
  - Counter at 0 → RUN.
- **RUN:** `core_rst`=0.
  - `core_terminate`=0 → `cycle_count` increments by 1, saturating at all-ones.
  - `core_terminate`=1 → the whole `core_o` is latched into the snapshot register, `cycle_count` freezes, read index clears to 0, next state DRAIN.
- **DRAIN:** `core_rst`=1, so the core is re-held.
  - `out_valid`=1 and `out_data`=snapshot word[index].
  - A transfer occurs when `out_valid` and `out_ready` are both high. On a transfer the index increments.
  - A transfer with index = OUT_MEM_SIZE-1 raises `done` for the next cycle and goes to IDLE.
- **Word stability:** `out_data`, `out_valid` and `out_last` stay stable while `out_ready`=0.
- **start outside IDLE:** ignored, not queued.
- **Index width:** clog2(OUT_MEM_SIZE), minimum 1 bit.

## Timing
- **Reset values:**
  - State IDLE; `core_rst`=1; `busy`=0; `done`=0; `timeout`=0.
  - `cycle_count`=0; `out_valid`=0; `out_last`=0; `out_data`=0; snapshot=0.
- **Start latency:** `start` asserted in cycle T gives `busy`=1 from T+1. `core_rst` falls at T+1+RST_CYCLES.
- **Cycle counting:** `cycle_count` equals the number of RUN-state edges sampled with `core_terminate`=0. If the core terminates on its first released cycle, the count is 0.
- **Terminate to stream:** `core_terminate` sampled in RUN at edge E gives `out_valid`=1 after E, starting with word 0.
- **Streaming rate:** with `out_ready` held high, one word per cycle. A full dump takes OUT_MEM_SIZE cycles.
- **done timing:** `done` is high in the cycle after the last handshake, with `busy`=0 in that same cycle.
- **Terminate during HOLD:** ignored.
- **Reset mid-run:** `rst` asynchronously forces all state to the reset values, including mid-stream. Partial dumps are discarded.

## Configuration
- **Macro `A23_RUN_TIMEOUT_EN` defined:**
  - In RUN, when `cycle_count` reaches MAX_CYCLES without terminate, `timeout` is set and the FSM goes to DRAIN as if terminated.
  - The snapshot holds `core_o` as of that edge, and the full dump still occurs.
- **Macro undefined:** no limit logic; RUN lasts until `core_terminate`; `timeout` is tied to 0.

## Test plan
- **Basic run:** OUT_MEM_SIZE=4, RST_CYCLES=3, `start` pulsed, core model asserts terminate after 10 released cycles, `out_ready`=1 → `core_rst` is low for exactly 11 edges, `cycle_count`=10, words 0..3 stream in 4 consecutive cycles, `out_last` is on word 3, and `done` pulses once.
- **Backpressure:** toggle `out_ready` 1,0,0,1,… during DRAIN → each word is held stable while `out_ready`=0. No word is skipped or duplicated, and values match the snapshot even if `core_o` changes after terminate.
- **Immediate terminate:** `core_terminate` is high on the first released cycle → `cycle_count`=0 and the dump proceeds normally.
- **start while busy:** pulse `start` during RUN and during DRAIN → no effect; a single `done`; counts unchanged.
- **Async reset mid-stream:** assert `rst` between edges after word 1 → all outputs return to reset values immediately. A new `start` afterwards runs cleanly from word 0.
- **Timeout (A23_RUN_TIMEOUT_EN, MAX_CYCLES=20):** terminate never asserted → `timeout`=1 and `cycle_count`=20, then a full dump and `done`. The next `start` clears `timeout`.
